// File: rtl/sub1p_hs.sv
// sub1p_hs: three-stage pipelined subtractor, diff = x - y mod 2^WIDTH.
// The operands are split into an LSB part (WIDTH1 bits) and an MSB part
// (WIDTH2 bits). Both parts are subtracted independently in stage 1, and the
// LSB borrow is folded into the MSB part in stage 2. A valid/ready handshake
// with a single global stall lets the block sit between elastic stages.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   x, y         minuend / subtrahend (WIDTH bits)
//   in_valid     x,y valid this cycle
//   in_ready     block accepts x,y this cycle (combinational)
//   diff         x - y mod 2^WIDTH
//   borrow_out   1 when x < y as unsigned
//   ovf          1 on two's-complement overflow of x - y
//   out_valid    diff/borrow_out/ovf valid
//   out_ready    downstream accepts result
//   LSBs_Borrow  test port: borrow bit of the stage-1 LSB register
module sub1p_hs #(
   parameter int WIDTH  = 19,
   parameter int WIDTH1 = 9,
   parameter int WIDTH2 = 10   // WIDTH1 + WIDTH2 must equal WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             LSBs_Borrow
);

   // Whole pipe advances together; it only stalls when a finished result
   // is sitting at the output and downstream refuses it.
   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Stage valid bits: [0] input reg, [1] partial differences, [2] output.
   logic [2:0] vld_pipe;
   assign out_valid = vld_pipe[2];

   // Stage 0: split operands.
   logic [WIDTH1-1:0] l1, l2;
   logic [WIDTH2-1:0] l3, l4;
   logic              sx0, sy0;

   // Stage 1: independent part differences, with their borrows in the MSB.
   logic [WIDTH1:0]   r1;
   logic [WIDTH2:0]   r2;
   logic              sx1, sy1;

   // Stage 2: result halves.
   logic [WIDTH1-1:0] s1;
   logic [WIDTH2-1:0] s2;

   // Fold the LSB borrow into the MSB part. A borrow out of either the
   // MSB subtraction or this fold-in means x < y overall; both cannot occur
   // together because r2 in [0, 2^WIDTH2) underflows only when it is zero.
   logic [WIDTH2:0]   t;
   assign t = r2 - {{WIDTH2{1'b0}}, r1[WIDTH1]};

   assign diff        = {s2, s1};
   assign LSBs_Borrow = r1[WIDTH1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe   <= '0;
         l1         <= '0;
         l2         <= '0;
         l3         <= '0;
         l4         <= '0;
         sx0        <= 1'b0;
         sy0        <= 1'b0;
         r1         <= '0;
         r2         <= '0;
         sx1        <= 1'b0;
         sy1        <= 1'b0;
         s1         <= '0;
         s2         <= '0;
         borrow_out <= 1'b0;
         ovf        <= 1'b0;
      end else if (en) begin
         vld_pipe   <= {vld_pipe[1:0], in_valid};
         // stage 0
         l1         <= x[WIDTH1-1:0];
         l2         <= y[WIDTH1-1:0];
         l3         <= x[WIDTH-1:WIDTH1];
         l4         <= y[WIDTH-1:WIDTH1];
         sx0        <= x[WIDTH-1];
         sy0        <= y[WIDTH-1];
         // stage 1
         r1         <= {1'b0, l1} - {1'b0, l2};
         r2         <= {1'b0, l3} - {1'b0, l4};
         sx1        <= sx0;
         sy1        <= sy0;
         // stage 2
         s1         <= r1[WIDTH1-1:0];
         s2         <= t[WIDTH2-1:0];
         borrow_out <= r2[WIDTH2] | t[WIDTH2];
         // Signed overflow: operands of opposite sign and result sign
         // differs from the minuend's sign.
         ovf        <= (sx1 != sy1) && (t[WIDTH2-1] != sx1);
      end
   end

endmodule

// File: doc/sub1p_hs.md
Name: sub1p_hs

Overview:
Three-stage pipelined subtractor computing diff = x - y (mod 2^WIDTH). It splits the operands into an LSB part and an MSB part, and the LSB borrow is resolved in a second stage. It is the subtracting counterpart of the team's split-carry pipelined adder, and it adds a valid/ready handshake with backpressure so it can sit between elastic DSP stages such as CIC combs, difference filters and error computation. It also outputs an unsigned borrow and a two's-complement overflow flag.

Parameters:
WIDTH, 19, total operand/result bit width
WIDTH1, 9, bit width of the LSB part
WIDTH2, 10, bit width of the MSB part; WIDTH1 + WIDTH2 = WIDTH required

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
x  input  WIDTH  minuend
y  input  WIDTH  subtrahend
in_valid  input  1  x,y valid this cycle
in_ready  output  1  block accepts x,y this cycle
diff  output  WIDTH  x - y mod 2^WIDTH
borrow_out  output  1  1 when x < y as unsigned
ovf  output  1  1 on signed (two's-complement) overflow of x - y
out_valid  output  1  diff/borrow_out/ovf valid
out_ready  input  1  downstream accepts result
LSBs_Borrow  output  1  test port: raw borrow bit of the stage-1 LSB register

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-low.
  - While reset = 0, every register clears: diff = 0, borrow_out = 0, ovf = 0, out_valid = 0, LSBs_Borrow = 0, and all stage valid bits = 0.
  - in_ready is combinational. It is 1 whenever out_valid = 0, including during reset.
- Global stall:
  - en = !out_valid || out_ready.
  - in_ready = en.
  - All pipeline registers, data and valid alike, update only when en = 1. When en = 0 everything holds.
- Stage 0 (input register), on an en edge:
  - l1 <= x[WIDTH1-1:0], l2 <= y[WIDTH1-1:0].
  - l3 <= x[WIDTH-1:WIDTH1], l4 <= y[WIDTH-1:WIDTH1].
  - sx <= x[WIDTH-1], sy <= y[WIDTH-1].
  - v0 <= in_valid.
  - A transfer occurs when in_valid && in_ready. With in_valid = 0, a bubble (v0 = 0) enters the pipe.
- Stage 1:
  - r1 (WIDTH1+1 bits) <= {1'b0,l1} - {1'b0,l2}.
  - r2 (WIDTH2+1 bits) <= {1'b0,l3} - {1'b0,l4}.
  - Sign bits sx, sy are forwarded. v1 <= v0.
  - LSBs_Borrow = r1[WIDTH1].
- Stage 2, registered outputs:
  - s1 <= r1[WIDTH1-1:0].
  - t = r2 - r1[WIDTH1], evaluated as WIDTH2+1 bits.
  - s2 <= t[WIDTH2-1:0].
  - diff = {s2,s1}.
  - borrow_out <= r2[WIDTH2] | t[WIDTH2].
  - ovf <= (sx != sy) && (t[WIDTH2-1] != sx).
  - out_valid <= v1.
- Latency:
  - A transfer at edge k gives out_valid = 1 after edge k+2, i.e. 3 register stages, provided en stays 1.
  - Throughput is one result per cycle when out_ready = 1.
- Data integrity:
  - Bubble stages carry don't-care data. diff/borrow_out/ovf are only meaningful while out_valid = 1.
  - While out_valid = 1 and out_ready = 0, diff/borrow_out/ovf/out_valid are stable.
  - No accepted word is lost or duplicated.
- Boundary conditions:
  - x = y gives diff = 0, borrow_out = 0, ovf = 0.
  - y = 0 gives diff = x.
  - Wrap-around is modulo 2^WIDTH.
  - An LSB borrow rippling through an all-zero MSB part sets borrow_out.
- Reset asserted mid-stream: all in-flight words are discarded. The first accepted word after reset deassertion appears with latency 3.

Test Plan:
- Reset: hold reset = 0 with random x/y/in_valid -> out_valid = 0, diff = 0, in_ready = 1; release -> nothing valid until a transfer.
- No borrow: x = 5, y = 3, out_ready = 1 -> after 3 edges diff = 2, borrow_out = 0, ovf = 0, out_valid pulse of 1 cycle.
- LSB borrow into MSB: x = 512, y = 1 -> LSBs_Borrow = 1 one cycle before the output; diff = 511 (0x001FF), borrow_out = 0. Also x = 0, y = 1 -> diff = 0x7FFFF, borrow_out = 1, ovf = 0.
- Signed overflow: x = 0x3FFFF, y = 0x40000 -> diff = 0x7FFFF, ovf = 1, borrow_out = 1. Also x = 0x40000, y = 1 -> diff = 0x3FFFF, ovf = 1, borrow_out = 0.
- Backpressure: stream x = 10,20,30,40 with y = 1 every cycle; drop out_ready for 2 cycles when the first result appears -> in_ready = 0 during the stall, 9 held stable, then outputs 9,19,29,39 in order with no loss or duplication.
- Reset mid-stream: assert reset with 3 words in flight -> out_valid = 0 immediately (asynchronous); after release, feed x = 7, y = 7 -> single result diff = 0, latency 3.
